// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for a single synchronous data-RAM port.
// Muxes the granted master onto the RAM and steers one-cycle-late read data back to the issuer.
module ram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter string       POLICY     = "FIXED",
    parameter int unsigned MAX_HOLD   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    input  logic                  m0_wr_w_i,
    input  logic                  m0_wr_h_i,
    input  logic                  m0_wr_b_i,
    input  logic                  m0_rd_i,
    output logic                  m0_gnt_o,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_rd_valid_o,

    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    input  logic                  m1_wr_w_i,
    input  logic                  m1_wr_h_i,
    input  logic                  m1_wr_b_i,
    input  logic                  m1_rd_i,
    output logic                  m1_gnt_o,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_rd_valid_o,

    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_cs_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic                  ram_write_w_o,
    output logic                  ram_write_h_o,
    output logic                  ram_write_b_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i
);

    localparam int unsigned   HOLD_W   = 4;
    localparam bit            RR       = (POLICY == "ROUND_ROBIN");
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic          OWN_M0   = 1'b0;
    localparam logic          OWN_M1   = 1'b1;

    logic              m0_wr, m1_wr;
    logic              m0_req, m1_req, both_req;
    logic              gnt0, gnt1;

    logic              last_owner_q, last_owner_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              rd_pend0_q, rd_pend0_d;
    logic              rd_pend1_q, rd_pend1_d;

    assign m0_wr    = m0_wr_w_i | m0_wr_h_i | m0_wr_b_i;
    assign m1_wr    = m1_wr_w_i | m1_wr_h_i | m1_wr_b_i;
    assign m0_req   = m0_rd_i | m0_wr;
    assign m1_req   = m1_rd_i | m1_wr;
    assign both_req = m0_req & m1_req;

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst_i) begin
            if (both_req) begin
                if (RR) begin
                    gnt1 = (last_owner_q == OWN_M0);
                end else begin
                    gnt1 = (last_owner_q == OWN_M0) && (hold_cnt_q == HOLD_MAX);
                end
                gnt0 = ~gnt1;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    // Ownership/hold bookkeeping and read-return tracking.
    always_comb begin
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        rd_pend0_d   = gnt0 & m0_rd_i & ~m0_wr;
        rd_pend1_d   = gnt1 & m1_rd_i & ~m1_wr;
        if (gnt0 || gnt1) begin
            last_owner_d = gnt1 ? OWN_M1 : OWN_M0;
            if ((last_owner_d == last_owner_q) && both_req) begin
                hold_cnt_d = (hold_cnt_q >= HOLD_MAX) ? HOLD_MAX : hold_cnt_q + HOLD_W'(1);
            end else begin
                hold_cnt_d = HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_owner_q <= OWN_M1;
            hold_cnt_q   <= '0;
            rd_pend0_q   <= 1'b0;
            rd_pend1_q   <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            rd_pend0_q   <= rd_pend0_d;
            rd_pend1_q   <= rd_pend1_d;
        end
    end

    // RAM port mux; idle port drives all zeros.
    always_comb begin
        ram_addr_o    = '0;
        ram_data_o    = '0;
        ram_write_w_o = 1'b0;
        ram_write_h_o = 1'b0;
        ram_write_b_o = 1'b0;
        if (gnt0) begin
            ram_addr_o    = m0_addr_i;
            ram_data_o    = m0_data_i;
            ram_write_w_o = m0_wr_w_i;
            ram_write_h_o = m0_wr_h_i;
            ram_write_b_o = m0_wr_b_i;
        end else if (gnt1) begin
            ram_addr_o    = m1_addr_i;
            ram_data_o    = m1_data_i;
            ram_write_w_o = m1_wr_w_i;
            ram_write_h_o = m1_wr_h_i;
            ram_write_b_o = m1_wr_b_i;
        end
    end

    assign ram_cs_o = gnt0 | gnt1;

    assign m0_gnt_o      = gnt0;
    assign m1_gnt_o      = gnt1;
    assign m0_rd_valid_o = rd_pend0_q;
    assign m1_rd_valid_o = rd_pend1_q;
    // Read data is gated to zero off-cycle so the returns can be OR-combined.
    assign m0_data_o     = rd_pend0_q ? ram_data_i : '0;
    assign m1_data_o     = rd_pend1_q ? ram_data_i : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: one FIXED and one ROUND_ROBIN instance share the
// same master stimulus; each has its own RAM model and expectation queues.
module tb_ram_port_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic          rd;
        logic          w;
        logic          h;
        logic          b;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mreq_t;

    typedef struct {
        int            g;
        logic          cs;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [2:0]    st;
    } gexp_t;

    typedef struct {
        int            due;
        int            m;
        logic [DW-1:0] d;
    } rexp_t;

    localparam mreq_t IDLE = '0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   boot = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic m0_w = 0, m0_h = 0, m0_b = 0, m0_rd = 0;
    logic m1_w = 0, m1_h = 0, m1_b = 0, m1_rd = 0;

    logic          gnt0 [2], gnt1 [2], vld0 [2], vld1 [2];
    logic [DW-1:0] rdat0 [2], rdat1 [2], ram_wdata [2];
    logic [AW-1:0] ram_addr [2];
    logic          ram_cs [2], ram_ww [2], ram_wh [2], ram_wb [2];
    logic [DW-1:0] ram_rdata_f, ram_rdata_r;
    logic [DW-1:0] mem_f [4096];
    logic [DW-1:0] mem_r [4096];

    gexp_t gq0[$], gq1[$];
    rexp_t rq0[$], rq1[$];

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POLICY("FIXED"), .MAX_HOLD(4)) u_fixed (
        .clk_i(clk), .rst_i(rst),
        .m0_addr_i(m0_addr), .m0_data_i(m0_wdata), .m0_wr_w_i(m0_w), .m0_wr_h_i(m0_h),
        .m0_wr_b_i(m0_b), .m0_rd_i(m0_rd), .m0_gnt_o(gnt0[0]), .m0_data_o(rdat0[0]),
        .m0_rd_valid_o(vld0[0]),
        .m1_addr_i(m1_addr), .m1_data_i(m1_wdata), .m1_wr_w_i(m1_w), .m1_wr_h_i(m1_h),
        .m1_wr_b_i(m1_b), .m1_rd_i(m1_rd), .m1_gnt_o(gnt1[0]), .m1_data_o(rdat1[0]),
        .m1_rd_valid_o(vld1[0]),
        .ram_addr_o(ram_addr[0]), .ram_cs_o(ram_cs[0]), .ram_data_o(ram_wdata[0]),
        .ram_write_w_o(ram_ww[0]), .ram_write_h_o(ram_wh[0]), .ram_write_b_o(ram_wb[0]),
        .ram_data_i(ram_rdata_f)
    );

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POLICY("ROUND_ROBIN"), .MAX_HOLD(4)) u_rr (
        .clk_i(clk), .rst_i(rst),
        .m0_addr_i(m0_addr), .m0_data_i(m0_wdata), .m0_wr_w_i(m0_w), .m0_wr_h_i(m0_h),
        .m0_wr_b_i(m0_b), .m0_rd_i(m0_rd), .m0_gnt_o(gnt0[1]), .m0_data_o(rdat0[1]),
        .m0_rd_valid_o(vld0[1]),
        .m1_addr_i(m1_addr), .m1_data_i(m1_wdata), .m1_wr_w_i(m1_w), .m1_wr_h_i(m1_h),
        .m1_wr_b_i(m1_b), .m1_rd_i(m1_rd), .m1_gnt_o(gnt1[1]), .m1_data_o(rdat1[1]),
        .m1_rd_valid_o(vld1[1]),
        .ram_addr_o(ram_addr[1]), .ram_cs_o(ram_cs[1]), .ram_data_o(ram_wdata[1]),
        .ram_write_w_o(ram_ww[1]), .ram_write_h_o(ram_wh[1]), .ram_write_b_o(ram_wb[1]),
        .ram_data_i(ram_rdata_r)
    );

    // Synchronous RAM models, preloaded while boot is high.
    always @(posedge clk) begin
        if (boot) begin
            mem_f[12'h010] <= 32'hDEADBEEF;
            mem_f[12'h011] <= 32'hCAFEF00D;
        end else if (ram_cs[0]) begin
            if (ram_ww[0])      mem_f[ram_addr[0]]       <= ram_wdata[0];
            else if (ram_wh[0]) mem_f[ram_addr[0]][15:0] <= ram_wdata[0][15:0];
            else if (ram_wb[0]) mem_f[ram_addr[0]][7:0]  <= ram_wdata[0][7:0];
            else                ram_rdata_f              <= mem_f[ram_addr[0]];
        end
    end

    always @(posedge clk) begin
        if (boot) begin
            mem_r[12'h010] <= 32'hDEADBEEF;
            mem_r[12'h011] <= 32'hCAFEF00D;
        end else if (ram_cs[1]) begin
            if (ram_ww[1])      mem_r[ram_addr[1]]       <= ram_wdata[1];
            else if (ram_wh[1]) mem_r[ram_addr[1]][15:0] <= ram_wdata[1][15:0];
            else if (ram_wb[1]) mem_r[ram_addr[1]][7:0]  <= ram_wdata[1][7:0];
            else                ram_rdata_r              <= mem_r[ram_addr[1]];
        end
    end

    function automatic mreq_t f_rd(input logic [AW-1:0] a);
        mreq_t r;
        r      = '0;
        r.rd   = 1'b1;
        r.addr = a;
        return r;
    endfunction

    function automatic mreq_t f_wrw(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mreq_t r;
        r      = '0;
        r.w    = 1'b1;
        r.addr = a;
        r.data = d;
        return r;
    endfunction

    function automatic gexp_t mk_g(input int g, input mreq_t a, input mreq_t b);
        gexp_t e;
        e.g = g; e.cs = 1'b0; e.addr = '0; e.wd = '0; e.st = '0;
        if (g == 1) begin
            e.cs = 1'b1; e.addr = a.addr; e.wd = a.data; e.st = {a.w, a.h, a.b};
        end else if (g == 2) begin
            e.cs = 1'b1; e.addr = b.addr; e.wd = b.data; e.st = {b.w, b.h, b.b};
        end
        return e;
    endfunction

    task automatic push_rd(input int k, input int g, input mreq_t a, input mreq_t b,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        rexp_t r;
        r.due = cyc + 1;
        r.m   = -1;
        if (g == 1 && a.rd && !(a.w || a.h || a.b)) begin r.m = 0; r.d = d0; end
        if (g == 2 && b.rd && !(b.w || b.h || b.b)) begin r.m = 1; r.d = d1; end
        if (r.m >= 0) begin
            if (k == 0) rq0.push_back(r);
            else        rq1.push_back(r);
        end
    endtask

    // One bus cycle: drive both masters, record hand-computed grants (FIXED, RR) and read returns.
    task automatic step(input mreq_t a, input mreq_t b, input logic r, input int g_f, input int g_r,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input bit ret);
        @(posedge clk);
        #1;
        rst = r;
        m0_rd = a.rd; m0_w = a.w; m0_h = a.h; m0_b = a.b; m0_addr = a.addr; m0_wdata = a.data;
        m1_rd = b.rd; m1_w = b.w; m1_h = b.h; m1_b = b.b; m1_addr = b.addr; m1_wdata = b.data;
        gq0.push_back(mk_g(g_f, a, b));
        gq1.push_back(mk_g(g_r, a, b));
        if (ret) begin
            push_rd(0, g_f, a, b, d0, d1);
            push_rd(1, g_r, a, b, d0, d1);
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s inst%0d cyc %0d: got %0h want %0h", nm, k, cyc, act, exp);
        else
            n_pass++;
    endtask

    task automatic mon(input int k);
        gexp_t ge;
        rexp_t re;
        bit    hg, hr, v0, v1;
        hg = 1'b0; hr = 1'b0;
        if (k == 0) begin
            if (gq0.size() != 0) begin ge = gq0.pop_front(); hg = 1'b1; end
            if (rq0.size() != 0 && rq0[0].due == cyc) begin re = rq0.pop_front(); hr = 1'b1; end
        end else begin
            if (gq1.size() != 0) begin ge = gq1.pop_front(); hg = 1'b1; end
            if (rq1.size() != 0 && rq1[0].due == cyc) begin re = rq1.pop_front(); hr = 1'b1; end
        end
        if (hg) begin
            chk("gnt", k, 64'({gnt1[k], gnt0[k]}), 64'(ge.g));
            chk("ram_cs", k, 64'(ram_cs[k]), 64'(ge.cs));
            chk("ram_addr", k, 64'(ram_addr[k]), 64'(ge.addr));
            chk("ram_wdata", k, 64'(ram_wdata[k]), 64'(ge.wd));
            chk("ram_strb", k, 64'({ram_ww[k], ram_wh[k], ram_wb[k]}), 64'(ge.st));
        end
        v0 = hr && (re.m == 0);
        v1 = hr && (re.m == 1);
        chk("m0_rd_valid", k, 64'(vld0[k]), 64'(v0));
        chk("m0_data", k, 64'(rdat0[k]), v0 ? 64'(re.d) : 64'd0);
        chk("m1_rd_valid", k, 64'(vld1[k]), 64'(v1));
        chk("m1_data", k, 64'(rdat1[k]), v1 ? 64'(re.d) : 64'd0);
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        int pf [10];
        int pr [10];
        mreq_t rb;
        pf = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
        pr = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2};

        step(IDLE, IDLE, 1'b1, 0, 0, '0, '0, 1'b0);
        step(IDLE, IDLE, 1'b1, 0, 0, '0, '0, 1'b0);
        boot = 1'b0;

        // Single read after reset, then a solo m1 read leaves last_owner = m1.
        step(f_rd(12'h010), IDLE, 1'b0, 1, 1, 32'hDEADBEEF, '0, 1'b1);
        step(IDLE, IDLE, 1'b0, 0, 0, '0, '0, 1'b0);
        step(IDLE, f_rd(12'h011), 1'b0, 2, 2, '0, 32'hCAFEF00D, 1'b1);

        // Continuous contention.
        for (int i = 0; i < 10; i++)
            step(f_rd(12'h010), f_rd(12'h011), 1'b0, pf[i], pr[i], 32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
        step(IDLE, IDLE, 1'b0, 0, 0, '0, '0, 1'b0);

        // m0 word write, m1 reads it back next cycle.
        step(f_wrw(12'h020, 32'h12345678), IDLE, 1'b0, 1, 1, '0, '0, 1'b1);
        step(IDLE, f_rd(12'h020), 1'b0, 2, 2, '0, 32'h12345678, 1'b1);
        step(IDLE, IDLE, 1'b0, 0, 0, '0, '0, 1'b0);

        // Read plus byte strobe is a write: no return.
        rb = '0; rb.rd = 1'b1; rb.b = 1'b1; rb.addr = 12'h030; rb.data = 32'h000000AB;
        step(IDLE, rb, 1'b0, 2, 2, '0, '0, 1'b1);
        step(IDLE, IDLE, 1'b0, 0, 0, '0, '0, 1'b0);

        // Granted m0 read is dropped by a reset arriving before its return.
        step(f_rd(12'h010), IDLE, 1'b0, 1, 1, '0, '0, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        step(f_rd(12'h010), f_rd(12'h011), 1'b1, 0, 0, '0, '0, 1'b0);
        step(f_rd(12'h010), f_rd(12'h011), 1'b1, 0, 0, '0, '0, 1'b0);
        step(f_rd(12'h010), f_rd(12'h011), 1'b0, 1, 1, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
        step(f_rd(12'h010), f_rd(12'h011), 1'b0, 1, 2, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
        step(IDLE, f_rd(12'h011), 1'b0, 2, 2, '0, 32'hCAFEF00D, 1'b1);

        for (int i = 0; i < 3; i++)
            step(IDLE, IDLE, 1'b0, 0, 0, '0, '0, 1'b0);
        @(negedge clk);
        #1;
        chk("reads_outstanding", 0, 64'(rq0.size()), 64'd0);
        chk("reads_outstanding", 1, 64'(rq1.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
